// File: rtl/serial_tx_pkg.sv
// Shared state encoding and line levels for the serial word transmitter.
package serial_tx_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t IDLE   = 3'd0;
    localparam tx_state_t START  = 3'd1;
    localparam tx_state_t DATA   = 3'd2;
    localparam tx_state_t PARITY = 3'd3;
    localparam tx_state_t STOP   = 3'd4;

    localparam logic IDLE_LVL  = 1'b0;
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, tick marks the last cycle of each period.
module serial_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial framer: start bit, data LSB-first, optional even parity, stop bit(s).
// Parity bit is compiled in when SERIAL_WORD_TX_PARITY_EN is defined.
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastData = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ser_q, ser_d;
    logic              done_q, done_d;
    logic              tick;
    logic              accept;

`ifdef SERIAL_WORD_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    assign data_ready = (state_q == IDLE) && !Reset;
    assign accept     = data_valid && data_ready;
    assign busy       = (state_q != IDLE);
    assign ser_out    = ser_q;
    assign done       = done_q;

    // Timer is held at zero while idle so the start bit gets a full period.
    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .CLK  (CLK),
        .Reset(Reset),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    buf_d   = data_in;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    buf_d = buf_q >> 1;
                    if (cnt_q == LastData) begin
                        cnt_d = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_WORD_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (cnt_q == LastStop) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state so it lines up with the state register.
    always_comb begin
        ser_d = IDLE_LVL;
        case (state_d)
            START:  ser_d = START_LVL;
            DATA:   ser_d = buf_d[0];
`ifdef SERIAL_WORD_TX_PARITY_EN
            PARITY: ser_d = parity_q;
`endif
            STOP:   ser_d = STOP_LVL;
            default: ser_d = IDLE_LVL;
        endcase
    end

`ifdef SERIAL_WORD_TX_PARITY_EN
    assign parity_d = accept ? ^data_in : parity_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            ser_q   <= IDLE_LVL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

endmodule
